// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming 3x3 2-D convolution ("valid" windows only) over a
// raster-order pixel stream, with double-buffered kernel and framing checks.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready     input pixel handshake; s_data pixel, s_last end of frame
//   kernel_in           nine signed coefficients, slice k = 3*i + j
//   kernel_load         one-cycle strobe, samples kernel_in into the shadow kernel
//   m_valid/m_ready     result handshake; m_data signed result, m_last end of frame
//   frame_err           sticky framing error, cleared only by reset
//
// Handshake: a beat transfers on a rising edge where valid && ready. A source
// holds valid and its payload stable until the transfer; ready may depend
// combinationally on the downstream ready (s_ready = !m_valid || m_ready).
//
// Build option: define CONV_RELU_EN to clamp negative results to zero.
//
// Pipeline (all stages hold together when the output is stalled):
//   taps    : 3x3 column shift register fed from the line memories
//   stage 1 : window register (plus the kernel that window must use)
//   stage 2 : nine products
//   stage 3 : adder tree, rounding, saturation into the output register
module conv2d_stream #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIX_W-1:0]      s_data,
  input  logic                  s_last,
  input  logic [9*COEF_W-1:0]   kernel_in,
  input  logic                  kernel_load,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_W-1:0]      m_data,
  output logic                  m_last,
  output logic                  frame_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = PIX_W + COEF_W + 1;
  localparam int SW = PW + 4;
  // Wide enough for the rounding add and for both saturation limits.
  localparam int XW = ((SW + 1 > OUT_W) ? SW + 1 : OUT_W) + 1;
  localparam logic signed [XW-1:0] RND =
    (SHIFT > 0) ? (XW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [XW-1:0] OMAX = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] OMIN = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                     advance, accept, at_end, at_origin;
  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic [PIX_W-1:0]         line0 [IMG_W];  // row r-2
  logic [PIX_W-1:0]         line1 [IMG_W];  // row r-1
  logic [PIX_W-1:0]         tap   [9];
  logic [PIX_W-1:0]         win   [9];
  logic signed [COEF_W-1:0] kin    [9];
  logic signed [COEF_W-1:0] shadow [9];
  logic signed [COEF_W-1:0] active [9];
  logic signed [COEF_W-1:0] kern1  [9];
  logic signed [PW-1:0]     prod_c [9];
  logic signed [PW-1:0]     prod   [9];
  logic                     v0, v1, v2, l0, l1, l2;
  logic signed [SW-1:0]     sum;
  logic signed [XW-1:0]     ext, rounded;
  logic signed [OUT_W-1:0]  result;

  assign advance   = !m_valid || m_ready;
  assign s_ready   = advance;
  assign accept    = s_valid && advance;
  assign at_end    = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign at_origin = (row == '0) && (col == '0);

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      kin[k]    = kernel_in[COEF_W*k +: COEF_W];
      prod_c[k] = $signed({{(PW-PIX_W){1'b0}}, win[k]}) *
                  $signed({{(PW-COEF_W){kern1[k][COEF_W-1]}}, kern1[k]});
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < 9; k++) sum = sum + $signed({{(SW-PW){prod[k][PW-1]}}, prod[k]});
    ext     = $signed({{(XW-SW){sum[SW-1]}}, sum});
    rounded = (ext + RND) >>> SHIFT;
    if (rounded > OMAX)      result = OMAX[OUT_W-1:0];
    else if (rounded < OMIN) result = OMIN[OUT_W-1:0];
    else                     result = rounded[OUT_W-1:0];
`ifdef CONV_RELU_EN
    if (result[OUT_W-1]) result = '0;
`endif
  end

  // Line memories carry no reset; stale contents never reach a valid window.
  always_ff @(posedge clk) begin
    if (accept) begin
      line0[col] <= line1[col];
      line1[col] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      frame_err <= 1'b0;
      v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0;
      l0 <= 1'b0; l1 <= 1'b0; l2 <= 1'b0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      for (int k = 0; k < 9; k++) begin
        tap[k] <= '0; win[k] <= '0; prod[k] <= '0;
        shadow[k] <= '0; active[k] <= '0; kern1[k] <= '0;
      end
    end else begin
      if (kernel_load) shadow <= kin;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          tap[3*i]   <= tap[3*i+1];
          tap[3*i+1] <= tap[3*i+2];
        end
        tap[2] <= line0[col];
        tap[5] <= line1[col];
        tap[8] <= s_data;
        // A load on the same beat as pixel (0,0) already counts for this frame.
        if (at_origin) active <= kernel_load ? kin : shadow;
        // Either framing violation still restarts at (0,0) on the next pixel.
        if (at_end || s_last) begin
          col <= '0;
          row <= '0;
          if (at_end != s_last) frame_err <= 1'b1;
        end else if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (advance) begin
        v0 <= accept && (row >= RW'(2)) && (col >= CW'(2));
        l0 <= accept && at_end;
        // The kernel travels with its window so a swap at the next frame's
        // first pixel cannot leak into the previous frame's last windows.
        win   <= tap;
        kern1 <= active;
        v1    <= v0;
        l1    <= l0;
        prod  <= prod_c;
        v2    <= v1;
        l2    <= l1;
        m_valid <= v2;
        m_last  <= l2;
        if (v2) m_data <= result;
      end
    end
  end

endmodule
